// File: rtl/roi_apb_regfile.sv
// APB register file for ROI_NUM regions of interest with shadow/active double buffering.
// Optional build macro ROI_SWAP_EN: inverted regions are normalised by swapping instead of rejected.
module roi_apb_regfile #(
    parameter int APB_DATA_W = 32,
    parameter int APB_ADDR_W = 12,
    parameter int ROI_NUM    = 4,
    parameter int COORD_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [APB_ADDR_W-1:0]        apb_paddr_i,
    input  logic [APB_DATA_W-1:0]        apb_pwdata_i,
    input  logic                         apb_pwrite_i,
    input  logic                         apb_psel_i,
    input  logic                         apb_penable_i,
    output logic                         apb_pready_o,
    output logic [APB_DATA_W-1:0]        apb_prdata_o,
    output logic                         apb_pslverr_o,
    input  logic                         frame_start_i,
    output logic [ROI_NUM*COORD_W-1:0]   roi_x0_o,
    output logic [ROI_NUM*COORD_W-1:0]   roi_y0_o,
    output logic [ROI_NUM*COORD_W-1:0]   roi_x1_o,
    output logic [ROI_NUM*COORD_W-1:0]   roi_y1_o,
    output logic [ROI_NUM-1:0]           roi_en_o,
    output logic                         roi_update_o
);

    localparam int IDX_W = APB_ADDR_W - 4;
    localparam logic [APB_ADDR_W-1:0] COMMIT_ADDR = APB_ADDR_W'(12'h800);
    localparam logic [APB_ADDR_W-1:0] STATUS_ADDR = APB_ADDR_W'(12'h804);

    typedef enum logic [0:0] {APB_IDLE = 1'b0, APB_ACCESS = 1'b1} apb_state_t;
    typedef enum logic [0:0] {CM_IDLE = 1'b0, CM_PENDING = 1'b1} cm_state_t;

    function automatic logic roi_inverted(input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] x1,
                                          input logic [COORD_W-1:0] y0, input logic [COORD_W-1:0] y1);
        return (x0 > x1) || (y0 > y1);
    endfunction

    apb_state_t apb_state_r, apb_state_s;
    cm_state_t  cm_state_r, cm_state_s;

    logic [COORD_W-1:0] sh_x0_r [ROI_NUM];
    logic [COORD_W-1:0] sh_y0_r [ROI_NUM];
    logic [COORD_W-1:0] sh_x1_r [ROI_NUM];
    logic [COORD_W-1:0] sh_y1_r [ROI_NUM];
    logic [COORD_W-1:0] act_x0_r [ROI_NUM];
    logic [COORD_W-1:0] act_y0_r [ROI_NUM];
    logic [COORD_W-1:0] act_x1_r [ROI_NUM];
    logic [COORD_W-1:0] act_y1_r [ROI_NUM];
    logic [COORD_W-1:0] cp_x0_s [ROI_NUM];
    logic [COORD_W-1:0] cp_y0_s [ROI_NUM];
    logic [COORD_W-1:0] cp_x1_s [ROI_NUM];
    logic [COORD_W-1:0] cp_y1_s [ROI_NUM];
    logic [ROI_NUM-1:0] sh_en_r, act_en_r, cp_en_s, rej_r, cp_rej_s;
    logic               sticky_r, update_r, pready_r, pslverr_r;
    logic [APB_DATA_W-1:0] prdata_r, rdata_s;

    logic [IDX_W-1:0]     roi_idx_s;
    logic                 roi_hit_s, commit_hit_s, status_hit_s, addr_ok_s;
    logic                 pready_s, fire_s, wr_s, pending_s, copy_s, commit_req_s;
    logic [2*COORD_W-1:0] xy0_rd_s, xy1_rd_s;
    logic                 en_rd_s;

    // Address decode; misaligned, reserved and out-of-range ROI addresses are errors
    always_comb begin
        roi_idx_s    = apb_paddr_i[APB_ADDR_W-1:4];
        roi_hit_s    = (roi_idx_s < IDX_W'(ROI_NUM)) && (apb_paddr_i[3:2] != 2'b11);
        commit_hit_s = (apb_paddr_i == COMMIT_ADDR);
        status_hit_s = (apb_paddr_i == STATUS_ADDR);
        addr_ok_s    = (apb_paddr_i[1:0] == 2'b00) && (roi_hit_s || commit_hit_s || status_hit_s);
    end

    // APB handshake next-state: one wait state, pready high for a single cycle
    always_comb begin
        apb_state_s = apb_state_r;
        pready_s    = 1'b0;
        fire_s      = 1'b0;
        case (apb_state_r)
            APB_IDLE: begin
                if (apb_psel_i && apb_penable_i) begin
                    apb_state_s = APB_ACCESS;
                end else begin
                    apb_state_s = APB_IDLE;
                end
            end
            APB_ACCESS: begin
                if (pready_r) begin
                    apb_state_s = APB_IDLE;
                end else if (apb_psel_i && apb_penable_i) begin
                    pready_s = 1'b1;
                    fire_s   = 1'b1;
                end else begin
                    apb_state_s = APB_IDLE;
                end
            end
            default: apb_state_s = APB_IDLE;
        endcase
        wr_s = fire_s && apb_pwrite_i && addr_ok_s;
    end

    // Commit FSM next-state; a commit arriving while idle always waits for the following frame
    always_comb begin
        pending_s    = (cm_state_r == CM_PENDING);
        commit_req_s = wr_s && commit_hit_s && apb_pwdata_i[0];
        copy_s       = pending_s && frame_start_i;
        cm_state_s   = cm_state_r;
        case (cm_state_r)
            CM_IDLE: begin
                if (commit_req_s) begin
                    cm_state_s = CM_PENDING;
                end else begin
                    cm_state_s = CM_IDLE;
                end
            end
            CM_PENDING: begin
                if (frame_start_i) begin
                    cm_state_s = CM_IDLE;
                end else begin
                    cm_state_s = CM_PENDING;
                end
            end
            default: cm_state_s = CM_IDLE;
        endcase
    end

    // Shadow read mux as an AND-OR over all regions
    always_comb begin
        xy0_rd_s = '0;
        xy1_rd_s = '0;
        en_rd_s  = 1'b0;
        for (int i = 0; i < ROI_NUM; i++) begin
            xy0_rd_s = xy0_rd_s | ({sh_y0_r[i], sh_x0_r[i]} & {(2*COORD_W){roi_idx_s == IDX_W'(i)}});
            xy1_rd_s = xy1_rd_s | ({sh_y1_r[i], sh_x1_r[i]} & {(2*COORD_W){roi_idx_s == IDX_W'(i)}});
            en_rd_s  = en_rd_s | (sh_en_r[i] & (roi_idx_s == IDX_W'(i)));
        end
    end

    // Read data selection
    always_comb begin
        rdata_s = '0;
        if (!addr_ok_s || apb_pwrite_i) begin
            rdata_s = '0;
        end else if (roi_hit_s) begin
            case (apb_paddr_i[3:2])
                2'b00:   rdata_s[2*COORD_W-1:0] = xy0_rd_s;
                2'b01:   rdata_s[2*COORD_W-1:0] = xy1_rd_s;
                2'b10:   rdata_s[0] = en_rd_s;
                default: rdata_s = '0;
            endcase
        end else if (commit_hit_s) begin
            rdata_s[0] = pending_s;
        end else begin
            rdata_s[0] = pending_s;
            rdata_s[1] = sticky_r;
            for (int i = 0; (i < ROI_NUM) && (i + 16 < APB_DATA_W); i++) begin
                rdata_s[16+i] = rej_r[i];
            end
        end
    end

    // Values loaded into the active set at commit time
    always_comb begin
        for (int i = 0; i < ROI_NUM; i++) begin
`ifdef ROI_SWAP_EN
            cp_x0_s[i]  = (sh_x0_r[i] > sh_x1_r[i]) ? sh_x1_r[i] : sh_x0_r[i];
            cp_x1_s[i]  = (sh_x0_r[i] > sh_x1_r[i]) ? sh_x0_r[i] : sh_x1_r[i];
            cp_y0_s[i]  = (sh_y0_r[i] > sh_y1_r[i]) ? sh_y1_r[i] : sh_y0_r[i];
            cp_y1_s[i]  = (sh_y0_r[i] > sh_y1_r[i]) ? sh_y0_r[i] : sh_y1_r[i];
            cp_en_s[i]  = sh_en_r[i];
            cp_rej_s[i] = 1'b0;
`else
            cp_x0_s[i]  = sh_x0_r[i];
            cp_x1_s[i]  = sh_x1_r[i];
            cp_y0_s[i]  = sh_y0_r[i];
            cp_y1_s[i]  = sh_y1_r[i];
            cp_rej_s[i] = roi_inverted(sh_x0_r[i], sh_x1_r[i], sh_y0_r[i], sh_y1_r[i]);
            cp_en_s[i]  = sh_en_r[i] & ~cp_rej_s[i];
`endif
        end
    end

    // State, APB response and status registers
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            apb_state_r <= APB_IDLE;
            cm_state_r  <= CM_IDLE;
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            prdata_r    <= '0;
            update_r    <= 1'b0;
            sticky_r    <= 1'b0;
            rej_r       <= '0;
        end else begin
            apb_state_r <= apb_state_s;
            cm_state_r  <= cm_state_s;
            pready_r    <= pready_s;
            pslverr_r   <= fire_s && !addr_ok_s;
            prdata_r    <= fire_s ? rdata_s : '0;
            update_r    <= copy_s;
            if (copy_s) begin
                rej_r <= cp_rej_s;
            end
            if (copy_s && (|cp_rej_s)) begin
                sticky_r <= 1'b1;
            end else if (wr_s && status_hit_s && apb_pwdata_i[1]) begin
                sticky_r <= 1'b0;
            end
        end
    end

    // Shadow and active region registers
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            sh_en_r  <= '0;
            act_en_r <= '0;
            for (int i = 0; i < ROI_NUM; i++) begin
                sh_x0_r[i]  <= '0;
                sh_y0_r[i]  <= '0;
                sh_x1_r[i]  <= '0;
                sh_y1_r[i]  <= '0;
                act_x0_r[i] <= '0;
                act_y0_r[i] <= '0;
                act_x1_r[i] <= '0;
                act_y1_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROI_NUM; i++) begin
                if (wr_s && roi_hit_s && (roi_idx_s == IDX_W'(i))) begin
                    case (apb_paddr_i[3:2])
                        2'b00: begin
                            sh_x0_r[i] <= apb_pwdata_i[COORD_W-1:0];
                            sh_y0_r[i] <= apb_pwdata_i[2*COORD_W-1:COORD_W];
                        end
                        2'b01: begin
                            sh_x1_r[i] <= apb_pwdata_i[COORD_W-1:0];
                            sh_y1_r[i] <= apb_pwdata_i[2*COORD_W-1:COORD_W];
                        end
                        2'b10:   sh_en_r[i] <= apb_pwdata_i[0];
                        default: sh_en_r[i] <= sh_en_r[i];
                    endcase
                end
            end
            if (copy_s) begin
                act_en_r <= cp_en_s;
                for (int i = 0; i < ROI_NUM; i++) begin
                    act_x0_r[i] <= cp_x0_s[i];
                    act_y0_r[i] <= cp_y0_s[i];
                    act_x1_r[i] <= cp_x1_s[i];
                    act_y1_r[i] <= cp_y1_s[i];
                end
            end
        end
    end

    for (genvar g = 0; g < ROI_NUM; g++) begin : g_pack
        assign roi_x0_o[g*COORD_W +: COORD_W] = act_x0_r[g];
        assign roi_y0_o[g*COORD_W +: COORD_W] = act_y0_r[g];
        assign roi_x1_o[g*COORD_W +: COORD_W] = act_x1_r[g];
        assign roi_y1_o[g*COORD_W +: COORD_W] = act_y1_r[g];
    end

    assign roi_en_o      = act_en_r;
    assign roi_update_o  = update_r;
    assign apb_pready_o  = pready_r;
    assign apb_prdata_o  = prdata_r;
    assign apb_pslverr_o = pslverr_r;

endmodule

// File: tb/tb_roi_apb_regfile.sv
// Self-checking bench for roi_apb_regfile; APB responses are checked through an expectation queue.
module tb_roi_apb_regfile;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [11:0] apb_paddr = 12'h000;
    logic [31:0] apb_pwdata = 32'h0;
    logic        apb_pwrite = 1'b0;
    logic        apb_psel = 1'b0;
    logic        apb_penable = 1'b0;
    logic        apb_pready;
    logic [31:0] apb_prdata;
    logic        apb_pslverr;
    logic        frame_start = 1'b0;
    logic [63:0] roi_x0, roi_y0, roi_x1, roi_y1;
    logic [3:0]  roi_en;
    logic        roi_update;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

`ifdef ROI_SWAP_EN
    localparam logic [31:0] EXP_STATUS_INV = 32'h0000_0000;
    localparam logic [31:0] EXP_STATUS_CLR = 32'h0000_0000;
    localparam logic [48:0] EXP_ROI1 = {16'h0010, 16'h0000, 16'h0050, 1'b1};
`else
    localparam logic [31:0] EXP_STATUS_INV = 32'h0002_0002;
    localparam logic [31:0] EXP_STATUS_CLR = 32'h0002_0000;
    localparam logic [48:0] EXP_ROI1 = {16'h0050, 16'h0000, 16'h0010, 1'b0};
`endif

    roi_apb_regfile dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .apb_paddr_i  (apb_paddr),
        .apb_pwdata_i (apb_pwdata),
        .apb_pwrite_i (apb_pwrite),
        .apb_psel_i   (apb_psel),
        .apb_penable_i(apb_penable),
        .apb_pready_o (apb_pready),
        .apb_prdata_o (apb_prdata),
        .apb_pslverr_o(apb_pslverr),
        .frame_start_i(frame_start),
        .roi_x0_o     (roi_x0),
        .roi_y0_o     (roi_y0),
        .roi_x1_o     (roi_x1),
        .roi_y1_o     (roi_y1),
        .roi_en_o     (roi_en),
        .roi_update_o (roi_update)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] sl(input logic [63:0] v, input int i);
        return v[i*16 +: 16];
    endfunction

    // Scoreboard: every completed transfer is matched against the oldest expectation
    always @(negedge clk_i) begin
        if (apb_pready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL apb_unexpected_pready: got pready=1 with no transfer outstanding, required none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (apb_prdata !== e.data || apb_pslverr !== e.err) begin
                    errors++;
                    $display("FAIL apb_resp addr=%h: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                             e.addr, apb_prdata, apb_pslverr, e.data, e.err);
                end
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic exp_err, input logic frame_at_fire);
        int waited;
        exp_q.push_back('{addr: addr, data: exp_data, err: exp_err});
        @(negedge clk_i);
        apb_psel = 1'b1; apb_pwrite = wr; apb_paddr = addr; apb_pwdata = wdata; apb_penable = 1'b0;
        @(negedge clk_i);
        apb_penable = 1'b1;
        waited = 0;
        do begin
            @(negedge clk_i);
            waited++;
            frame_start = (frame_at_fire && waited == 1) ? 1'b1 : 1'b0;
        end while (apb_pready !== 1'b1 && waited < 8);
        checks++;
        if (waited != 2) begin
            errors++;
            $display("FAIL apb_latency addr=%h: got %0d cycles to pready, required 2", addr, waited);
        end
        apb_psel = 1'b0; apb_penable = 1'b0; frame_start = 1'b0;
        @(negedge clk_i);
        checks++;
        if (apb_pready !== 1'b0) begin
            errors++;
            $display("FAIL apb_pready_width addr=%h: got pready=%b one cycle later, required 0", addr, apb_pready);
        end
    endtask

    task automatic pulse_frame(input logic exp_upd);
        @(negedge clk_i);
        frame_start = 1'b1;
        @(negedge clk_i);
        frame_start = 1'b0;
        checks++;
        if (roi_update !== exp_upd) begin
            errors++;
            $display("FAIL frame_update: got roi_update=%b, required %b", roi_update, exp_upd);
        end
        @(negedge clk_i);
        checks++;
        if (roi_update !== 1'b0) begin
            errors++;
            $display("FAIL frame_update_width: got roi_update=%b, required 0", roi_update);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        arst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({roi_x0, roi_y0, roi_x1, roi_y1, roi_en, roi_update, apb_pready, apb_prdata, apb_pslverr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got x0=%h y0=%h x1=%h y1=%h en=%h upd=%b rdy=%b, required all 0",
                     roi_x0, roi_y0, roi_x1, roi_y1, roi_en, roi_update, apb_pready);
        end
        apb_xfer(1'b0, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h800, 32'h0, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h804, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_commit();
        apb_xfer(1'b1, 12'h000, 32'h0020_0010, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h004, 32'h0080_0040, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h008, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h000, 32'h0, 32'h0020_0010, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h008, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        checks++;
        if (roi_en !== 4'h0 || roi_x0 !== 64'h0) begin
            errors++;
            $display("FAIL commit_before: got en=%h x0=%h, required en=0 x0=0", roi_en, roi_x0);
        end
        apb_xfer(1'b1, 12'h800, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h800, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h804, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        pulse_frame(1'b1);
        checks++;
        if ({sl(roi_x0, 0), sl(roi_y0, 0), sl(roi_x1, 0), sl(roi_y1, 0), roi_en} !==
            {16'h0010, 16'h0020, 16'h0040, 16'h0080, 4'h1}) begin
            errors++;
            $display("FAIL commit_roi0: got x0=%h y0=%h x1=%h y1=%h en=%h, required 10 20 40 80 1",
                     sl(roi_x0, 0), sl(roi_y0, 0), sl(roi_x1, 0), sl(roi_y1, 0), roi_en);
        end
        apb_xfer(1'b0, 12'h804, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_pending_rewrite();
        apb_xfer(1'b1, 12'h800, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h000, 32'h0000_0005, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h800, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({sl(roi_x0, 0), sl(roi_y0, 0)} !== {16'h0010, 16'h0020}) begin
            errors++;
            $display("FAIL pending_hold: got x0=%h y0=%h, required 10 20", sl(roi_x0, 0), sl(roi_y0, 0));
        end
        pulse_frame(1'b1);
        checks++;
        if ({sl(roi_x0, 0), sl(roi_y0, 0), sl(roi_x1, 0), sl(roi_y1, 0), roi_en} !==
            {16'h0005, 16'h0000, 16'h0040, 16'h0080, 4'h1}) begin
            errors++;
            $display("FAIL pending_load: got x0=%h y0=%h x1=%h y1=%h en=%h, required 5 0 40 80 1",
                     sl(roi_x0, 0), sl(roi_y0, 0), sl(roi_x1, 0), sl(roi_y1, 0), roi_en);
        end
        pulse_frame(1'b0);
    endtask

    task automatic test_invalid_roi();
        apb_xfer(1'b1, 12'h010, 32'h0000_0050, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h014, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h018, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h800, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
        pulse_frame(1'b1);
        checks++;
        if ({sl(roi_x0, 1), sl(roi_y0, 1), sl(roi_x1, 1), roi_en[1]} !== EXP_ROI1 || roi_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL invalid_roi1: got x0=%h y0=%h x1=%h en=%h, required %h en0=1",
                     sl(roi_x0, 1), sl(roi_y0, 1), sl(roi_x1, 1), roi_en, EXP_ROI1);
        end
        apb_xfer(1'b0, 12'h804, 32'h0, EXP_STATUS_INV, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h804, 32'h0000_0002, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h804, 32'h0, EXP_STATUS_CLR, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        apb_xfer(1'b0, 12'h0C2, 32'h0, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b0, 12'h900, 32'h0, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b0, 12'h040, 32'h0, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b1, 12'h040, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b1, 12'h002, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b1, 12'h00C, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b1, 12'h802, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b1, 12'h806, 32'h0000_0002, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b0, 12'h000, 32'h0, 32'h0000_0005, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h800, 32'h0, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h804, 32'h0, EXP_STATUS_CLR, 1'b0, 1'b0);
    endtask

    task automatic test_commit_frame_reset();
        apb_xfer(1'b1, 12'h004, 32'h00FF_00EE, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b1, 12'h800, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
        checks++;
        if (sl(roi_x1, 0) !== 16'h0040 || roi_update !== 1'b0) begin
            errors++;
            $display("FAIL coincident_no_copy: got x1=%h upd=%b, required 40 0", sl(roi_x1, 0), roi_update);
        end
        apb_xfer(1'b0, 12'h800, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        apply_reset();
        apb_xfer(1'b0, 12'h800, 32'h0, 32'h0, 1'b0, 1'b0);
        apb_xfer(1'b0, 12'h004, 32'h0, 32'h0, 1'b0, 1'b0);
        pulse_frame(1'b0);
        checks++;
        if ({roi_x0, roi_y0, roi_x1, roi_y1, roi_en} !== '0) begin
            errors++;
            $display("FAIL reset_pending_lost: got x0=%h x1=%h en=%h, required all 0", roi_x0, roi_x1, roi_en);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_pending_rewrite();
        test_invalid_roi();
        test_errors();
        test_commit_frame_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/roi_apb_regfile.md
Name: roi_apb_regfile

Overview:
Parametrised APB slave holding ROI_NUM rectangular regions of interest. Each region has x0/y0/x1/y1 coordinates and an enable bit. Software writes shadow registers, then requests a commit. The shadow set is copied atomically into the active set on the next frame_start_i pulse, so the downstream pixel pipeline never sees a half-updated ROI. Replaces the single-pair XY register block and sits between the APB interconnect and the ROI crop/stat engines.

Parameters:
APB_DATA_W, 32, APB data width; must be >= 2*COORD_W.
APB_ADDR_W, 12, APB address width.
ROI_NUM, 4, number of regions, range 1..64.
COORD_W, 16, width of one coordinate.

Ports:
clk_i  in  1  clock
arst_i  in  1  reset; synchronous, active-high (despite the name, sampled only on posedge clk_i)
apb_paddr_i  in  APB_ADDR_W  address
apb_pwdata_i  in  APB_DATA_W  write data
apb_pwrite_i  in  1  1 = write
apb_psel_i  in  1  select
apb_penable_i  in  1  access phase
apb_pready_o  out  1  transfer complete
apb_prdata_o  out  APB_DATA_W  read data, valid while pready=1
apb_pslverr_o  out  1  error, valid while pready=1
frame_start_i  in  1  one-cycle pulse at each frame boundary
roi_x0_o  out  ROI_NUM*COORD_W  active x0, ROI i in slice [i*COORD_W +: COORD_W]; same packing for the next three ports
roi_y0_o  out  ROI_NUM*COORD_W  active y0
roi_x1_o  out  ROI_NUM*COORD_W  active x1
roi_y1_o  out  ROI_NUM*COORD_W  active y1
roi_en_o  out  ROI_NUM  active enables
roi_update_o  out  1  one-cycle pulse when the active set is loaded

Behaviour:
- Reset (sync, arst_i=1 at posedge): all shadow and active registers = 0; pready/prdata/pslverr = 0; roi_update_o = 0; commit FSM = IDLE; STATUS = 0.
- Register map, word addresses:
  - ROI i base = 0x10*i.
  - +0x0 XY0 = {y0 at [2*COORD_W-1:COORD_W], x0 at [COORD_W-1:0]}.
  - +0x4 XY1 = {y1, x1}, same layout.
  - +0x8 CTRL, bit0 = enable.
  - +0xC reserved.
  - 0x800 COMMIT: write bit0=1 requests a commit; reads return the pending flag.
  - 0x804 STATUS: bit0 = pending; bit1 = invalid-ROI sticky, write 1 to clear; bits [16+i] = ROI i was rejected at the last commit (RO).
  - Unused upper data bits read 0.
- Error response: any other address, paddr[1:0] != 0, or ROI index >= ROI_NUM gives pslverr=1 with pready, prdata=0, and no state change.
- Reads return shadow values.
- APB handshake FSM:
  - IDLE→ACCESS when psel & penable; pready is registered and rises one cycle later (exactly one wait state).
  - ACCESS→IDLE the cycle after pready=1; pready is high for exactly one cycle.
  - Write side effects and prdata capture occur on the cycle pready_next is set, so the write is visible when pready=1.
  - psel dropping before pready returns the FSM to IDLE with no side effects.
- Commit FSM:
  - IDLE→PENDING on a COMMIT write with bit0=1.
  - PENDING→IDLE on frame_start_i. On that cycle all shadow registers are copied to active, and roi_update_o=1 the following cycle (same cycle as active outputs change).
  - COMMIT write while already PENDING: no effect; stays pending.
  - COMMIT write completing in the same cycle as frame_start_i while IDLE: becomes PENDING; the copy waits for the next frame_start_i.
  - Shadow write in the same cycle as the copy: the copy uses the pre-write shadow value.
- Validity at copy: ROI with x0>x1 or y0>y1 (unsigned) gets its coordinates copied, active enable forced 0, STATUS[16+i]=1 and STATUS[1]=1.
- Reset mid-transfer or while PENDING: everything returns to reset state; the pending commit is lost.

Optional Feature:
ROI_SWAP_EN: when defined, an inverted ROI is not rejected. At copy, x0/x1 and/or y0/y1 are swapped so that active x0<=x1 and y0<=y1, the enable passes through unchanged, and STATUS[1] and bits[16+i] are not set. When undefined, the rejection behaviour above applies.

Test Plan:
- Reset, then read 0x000, 0x800, 0x804 → prdata 0, pslverr 0, pready exactly 1 cycle after the penable cycle; all roi_* outputs 0.
- Write ROI0 XY0=0x0020_0010, XY1=0x0080_0040, CTRL=1, COMMIT=1, pulse frame_start_i → roi_x0[0]=0x10, y0=0x20, x1=0x40, y1=0x80, en[0]=1, roi_update_o pulse once; STATUS reads 0 afterwards.
- Commit pending, rewrite ROI0 XY0=0x5 before frame_start_i → active unchanged until the pulse, then takes 0x5; a second frame_start_i produces no roi_update_o.
- ROI1 XY0=0x0000_0050, XY1=0x0000_0010, CTRL=1, commit+frame → without ROI_SWAP_EN: en[1]=0, STATUS=0x0002_0002; with it: x0=0x10, x1=0x50, en[1]=1, STATUS=0.
- Access 0x0C2, 0x900, and ROI index ROI_NUM → pslverr=1, prdata=0, no register changes.
- COMMIT write coinciding with frame_start_i, then assert arst_i while PENDING → no copy happens; after reset the pending flag is 0 and a later frame_start_i does nothing.
